thor2023_dcache_rd: RTL
=======================

# thor2023_dcache_rd

Read-side (load) port of the Thor2023 data cache, the consumer of the lines and bytes the dcache write-enable logic places in the cache RAM. It accepts one load request at a time, reads the cache RAM, compares tags, and extracts and extends the addressed bytes. On a miss it requests a line fill and replays the lookup. Non-cacheable (`acr[3]==0`) loads bypass the RAM through the same fill handshake. The block sits between the memory-stage load queue and the dcache RAM / bus-interface unit.

## Interface
- `WID`, 512: cache line width in bits; line bytes `LB=WID/8`, a power of two.
- `IDXW`, 7: line index width (128 lines).
- `DW`, 128: load result width.
- `TAGW`, derived as `32-IDXW-$clog2(LB)`: tag width.

Ports:
- `clk`  in  1  clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `req_valid`/`req_ready`  in/out  1  request handshake; transfer when both are high.
- `req_adr`  in  32  byte address.
- `req_sz`  in  3  access size: 0 byte, 1 wyde, 2 tetra, 3 octa, 4 hexi; 5–7 reserved.
- `req_sign`  in  1  sign-extend the result.
- `req_acr`  in  4  access rights; bit 3 = cacheable.
- `ram_rd`  out  1  cache RAM read strobe.
- `ram_idx`  out  IDXW  line index, `adr[IDXW+log2(LB)-1:log2(LB)]`.
- `ram_tag`/`ram_valid`/`ram_dat`  in  TAGW/1/WID  RAM outputs, valid one cycle after `ram_rd`.
- `miss_req`  out  1  fill request, level signal.
- `miss_adr`  out  32  fill address: line-aligned when cached, exact when uncached.
- `miss_uncached`  out  1  uncached single access.
- `miss_ack`  in  1  one-cycle fill-complete pulse.
- `miss_dat`  in  DW  uncached data, byte-aligned to `adr[3:0]`.
- `resp_valid`/`resp_ready`  out/in  1  response handshake.
- `resp_dat`  out  DW  extended load data.
- `resp_err`  out  1  alignment or size error.
- `resp_hit`  out  1  served on the first lookup.

## Operation
- States: IDLE, LOOKUP, CMP, MISS, RESP.
- **IDLE.** `req_ready=1`. On a transfer the block registers the request.
  - Reserved `sz`, or offset `o=adr[log2(LB)-1:0]` with `o + 2^sz > LB`: go to RESP with `err=1`, `dat=0`. No RAM access and no miss request.
  - `acr[3]==0`: go to MISS with `miss_uncached=1`, `miss_adr=adr`.
  - Otherwise: go to LOOKUP with `ram_rd=1`, and set the first-try flag.
- **LOOKUP.** `ram_rd` is high for exactly one cycle. Go to CMP.
- **CMP.** Hit when `ram_valid && ram_tag==adr[31:32-TAGW]`.
  - Hit: `resp_dat = ext((ram_dat >> 8*o)[8*2^sz-1:0])`, `resp_hit` = first-try flag, go to RESP.
  - Miss: clear the first-try flag, go to MISS with `miss_adr = adr & ~(LB-1)`.
- **MISS.** `miss_req` stays high until `miss_ack` is sampled; `miss_req` is low in the following cycle.
  - Cached: go to LOOKUP (replay). Repeated misses replay without limit.
  - Uncached: capture `ext(miss_dat >> 8*adr[3:0])` and go to RESP with `resp_hit=0`.
- **RESP.** `resp_valid=1`; `resp_dat`, `resp_err` and `resp_hit` are held stable until `resp_ready`, then return to IDLE.
- `miss_ack` outside MISS is ignored.
- `ext` zero-extends, or sign-extends from the top selected bit when `req_sign=1`.

## Timing
- Reset values: all outputs 0, state IDLE. `req_ready` rises in the first cycle after `rst` deasserts.
- Reset mid-operation, in any state: abandon the access. `miss_req` and `resp_valid` are 0 in the next cycle, and no response is produced.
- Request accepted at edge T:
  - Hit: `ram_rd` during T+1, CMP during T+2, `resp_valid` from T+3.
  - Error: `resp_valid` from T+1.
  - Cached miss: `miss_req` from T+3. If `miss_ack` arrives at edge A: `ram_rd` during A+1, `resp_valid` from A+3 on a replay hit.
  - Uncached: `miss_req` from T+1; `resp_valid` from A+1.
- Blocking: one access in flight. `req_ready=0` in every state except IDLE.

## Structure
- Shared package (Thor2023Pkg):
  - load-size enum `load_sz_t`;
  - `dcache_rd_state_t`;
  - line-offset width constant derived from `DCacheLineWidth`.
- One combinational sub-module, `thor2023_load_align`: `(line, offset, sz, sign) -> DW` result. It is used for both the RAM and the uncached paths.

## Test plan
- Hit:
  - Stimulus: `adr=0x00001008`, `sz=2`, `sign=1`, `acr=0xF`, tag match, line bytes 8..11 = `00 00 00 80`.
  - Response: `resp_valid` at T+3, `resp_dat` = sign-extended `0x80000000` (all upper bits 1), `resp_hit=1`, `resp_err=0`.
- Cached miss:
  - Stimulus: `ram_valid=0` on first lookup; `adr=0x00001024`; `miss_ack` 5 cycles after `miss_req` rises; replay hits.
  - Response: `miss_adr=0x00001000`, `miss_uncached=0`; `miss_req` drops after the ack; second `ram_rd` pulse; `resp_hit=0`.
- Uncached:
  - Stimulus: `acr=0x7`, `adr=0x00002003`, `sz=0`, `sign=0`, `miss_dat` byte 3 = `0xF0`.
  - Response: no `ram_rd`; `miss_adr=0x00002003`, `miss_uncached=1`; `resp_dat=0xF0`.
- Line crossing:
  - Stimulus: `adr=0x0000103C`, `sz=3`.
  - Response: `resp_err=1` at T+1; no `ram_rd` and no `miss_req`. The same result for `sz=6`.
- Backpressure:
  - Stimulus: hold `resp_ready=0` for 4 cycles on a hit.
  - Response: `resp_*` stable; `req_ready=0` throughout; the block accepts a new request one cycle after `resp_ready`.
- Reset in MISS:
  - Stimulus: assert `rst` for 1 cycle while `miss_req=1`; pulse `miss_ack` 2 cycles later.
  - Response: `miss_req=0` the next cycle; the ack is ignored; no `resp_valid`; `req_ready=1`.

Source files
------------

// File: rtl/thor2023_dcache_rd_pkg.sv
// Shared types and line geometry for the Thor2023 dcache load port.
package thor2023_dcache_rd_pkg;

  localparam int DCacheLineWidth = 512;
  localparam int DCacheOffsW     = $clog2(DCacheLineWidth / 8);

  typedef enum logic [2:0] {
    LD_BYTE  = 3'd0,
    LD_WYDE  = 3'd1,
    LD_TETRA = 3'd2,
    LD_OCTA  = 3'd3,
    LD_HEXI  = 3'd4
  } load_sz_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_CMP,
    ST_MISS,
    ST_RESP
  } dcache_rd_state_t;

endpackage

// File: rtl/thor2023_load_align.sv
// Selects the addressed bytes from a line and zero/sign-extends them to DW bits.
module thor2023_load_align
  import thor2023_dcache_rd_pkg::*;
#(
  parameter int LW = DCacheLineWidth,
  parameter int OW = DCacheOffsW,
  parameter int DW = 128
)(
  input  logic [LW-1:0] line,
  input  logic [OW-1:0] offset,
  input  logic [2:0]    sz,
  input  logic          sign,
  output logic [DW-1:0] res
);

  logic [DW-1:0] sh;
  logic          msb;
  int            nbits;

  assign sh = DW'(line >> {offset, 3'b000});

  always_comb begin
    case (load_sz_t'(sz))
      LD_BYTE:  nbits = 8;
      LD_WYDE:  nbits = 16;
      LD_TETRA: nbits = 32;
      LD_OCTA:  nbits = 64;
      LD_HEXI:  nbits = 128;
      default:  nbits = DW;
    endcase
    if (nbits > DW) nbits = DW;
    msb = 1'b0;
    for (int i = 0; i < DW; i++)
      if (i == nbits - 1) msb = sh[i];
    for (int i = 0; i < DW; i++)
      res[i] = (i < nbits) ? sh[i] : (sign & msb);
  end

endmodule

// File: rtl/thor2023_dcache_rd.sv
// Blocking single-access load port: RAM lookup, tag compare, fill/replay and
// uncached bypass, with byte extraction and extension of the result.
module thor2023_dcache_rd
  import thor2023_dcache_rd_pkg::*;
#(
  parameter int WID  = DCacheLineWidth,
  parameter int IDXW = 7,
  parameter int DW   = 128,
  parameter int TAGW = 32 - IDXW - $clog2(WID / 8)
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_adr,
  input  logic [2:0]      req_sz,
  input  logic            req_sign,
  input  logic [3:0]      req_acr,
  output logic            ram_rd,
  output logic [IDXW-1:0] ram_idx,
  input  logic [TAGW-1:0] ram_tag,
  input  logic            ram_valid,
  input  logic [WID-1:0]  ram_dat,
  output logic            miss_req,
  output logic [31:0]     miss_adr,
  output logic            miss_uncached,
  input  logic            miss_ack,
  input  logic [DW-1:0]   miss_dat,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [DW-1:0]   resp_dat,
  output logic            resp_err,
  output logic            resp_hit
);

  localparam int LB  = WID / 8;
  localparam int OW  = $clog2(LB);
  localparam int UOW = $clog2(DW / 8);

  dcache_rd_state_t state;
  logic [31:0]      adr_q;
  logic [2:0]       sz_q;
  logic             sign_q;
  logic             first_try;
  logic [DW-1:0]    ram_res;
  logic [DW-1:0]    unc_res;
  logic [31:0]      req_end;
  logic             req_bad;
  logic             hit;
  logic             unused_acr;

  // Only the cacheable bit matters to the load port.
  assign unused_acr = ^req_acr[2:0];

  assign ram_idx = adr_q[OW +: IDXW];
  assign req_end = 32'(req_adr[OW-1:0]) + (32'd1 << req_sz);
  assign req_bad = (req_sz > LD_HEXI) || (req_end > 32'(LB));
  assign hit     = ram_valid && (ram_tag == adr_q[31 -: TAGW]);

  thor2023_load_align #(.LW(WID), .OW(OW), .DW(DW)) u_ram_align (
    .line   (ram_dat),
    .offset (adr_q[OW-1:0]),
    .sz     (sz_q),
    .sign   (sign_q),
    .res    (ram_res)
  );

  // Uncached data arrives aligned to the low address bits of a DW-wide beat.
  thor2023_load_align #(.LW(DW), .OW(UOW), .DW(DW)) u_unc_align (
    .line   (miss_dat),
    .offset (adr_q[UOW-1:0]),
    .sz     (sz_q),
    .sign   (sign_q),
    .res    (unc_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      adr_q         <= '0;
      sz_q          <= '0;
      sign_q        <= 1'b0;
      first_try     <= 1'b0;
      req_ready     <= 1'b0;
      ram_rd        <= 1'b0;
      miss_req      <= 1'b0;
      miss_adr      <= '0;
      miss_uncached <= 1'b0;
      resp_valid    <= 1'b0;
      resp_dat      <= '0;
      resp_err      <= 1'b0;
      resp_hit      <= 1'b0;
    end else begin
      ram_rd <= 1'b0;
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            adr_q     <= req_adr;
            sz_q      <= req_sz;
            sign_q    <= req_sign;
            if (req_bad) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_dat   <= '0;
              resp_hit   <= 1'b0;
            end else if (!req_acr[3]) begin
              state         <= ST_MISS;
              miss_req      <= 1'b1;
              miss_adr      <= req_adr;
              miss_uncached <= 1'b1;
            end else begin
              state     <= ST_LOOKUP;
              ram_rd    <= 1'b1;
              first_try <= 1'b1;
            end
          end
        end
        ST_LOOKUP: state <= ST_CMP;
        ST_CMP: begin
          if (hit) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_dat   <= ram_res;
            resp_err   <= 1'b0;
            resp_hit   <= first_try;
          end else begin
            state         <= ST_MISS;
            first_try     <= 1'b0;
            miss_req      <= 1'b1;
            miss_adr      <= adr_q & ~32'(LB - 1);
            miss_uncached <= 1'b0;
          end
        end
        ST_MISS: begin
          if (miss_ack) begin
            miss_req <= 1'b0;
            if (miss_uncached) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_dat   <= unc_res;
              resp_err   <= 1'b0;
              resp_hit   <= 1'b0;
            end else begin
              // Fill done: replay the lookup; a further miss simply loops again.
              state  <= ST_LOOKUP;
              ram_rd <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
